adc_frame_scheduler: RTL and testbench

Sample-frame scheduler for the ADC serial wrapper. It issues a one-cycle conversion-trigger pulse on the wrapper's `SYNC` input at a programmable period, then collects the resulting `RD_EN`/`DATA_O`/`CHANNEL` strobes into a per-channel latest-sample bank. Once every enabled channel has reported, or the collect watchdog expires, it signals frame completion. It sits in the `clk` domain between the wrapper and the downstream processing and host-register logic.

---
 rtl/adc_frame_scheduler.sv | 148 ++++++++++++++
 tb/tb_adc_frame_scheduler.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_frame_scheduler.sv
// rtl/adc_frame_scheduler.sv - ADC sample-frame scheduler with per-channel latest-sample bank
// Issues SYNC at a programmable period, collects channel strobes, reports frame completion.
module adc_frame_scheduler #(
  parameter int PERIOD_W = 16,
  parameter int TIMEOUT  = 4096
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                op_mode,
  input  logic [PERIOD_W-1:0] period,
  input  logic [7:0]          ch_mask,
  input  logic                rd_en,
  input  logic [15:0]         data_i,
  input  logic [2:0]          channel_i,
  input  logic                err_clr,
  input  logic [2:0]          rd_addr,
  output logic                sync_o,
  output logic [15:0]         rd_data,
  output logic                frame_done,
  output logic                frame_partial,
  output logic [7:0]          frame_got,
  output logic [15:0]         frame_cnt,
  output logic                busy,
  output logic                missed_tick,
  output logic                dup_err,
  output logic                stray_err,
  output logic                timeout_err
);

  localparam int              WD_W    = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_COLLECT, S_DONE} state_t;

  state_t              r_state;
  logic [PERIOD_W-1:0] r_tcnt;
  logic [WD_W-1:0]     r_wdog;
  logic [7:0]          r_mask;
  logic [7:0]          r_got;
  logic [15:0]         r_bank [8];

  logic                w_run;
  logic                w_tick;
  logic [PERIOD_W-1:0] w_period;
  logic                w_collect;
  logic                w_hit;
  logic [7:0]          w_new;
  logic                w_complete;
  logic                w_tout;
  logic                w_dup;
  logic                w_stray;
  logic                w_missed;

  assign w_run      = en & op_mode;
  assign w_tick     = w_run & (r_tcnt == '0);
  assign w_period   = (period < PERIOD_W'(2)) ? PERIOD_W'(2) : period;
  assign w_collect  = w_run & (r_state == S_COLLECT);
  assign w_hit      = w_collect & rd_en & r_mask[channel_i];
  assign w_new      = r_got | (w_hit ? (8'b1 << channel_i) : 8'h00);
  assign w_complete = w_collect & (w_new == r_mask);
  assign w_tout     = w_collect & ~w_complete & (r_wdog == WD_LAST);
  assign w_dup      = w_hit & r_got[channel_i];
  assign w_stray    = rd_en & (r_state != S_COLLECT);
  assign w_missed   = w_tick & ((r_state == S_COLLECT) || (r_state == S_DONE));

  assign rd_data = r_bank[rd_addr];
  assign busy    = (r_state == S_COLLECT) || (r_state == S_DONE);

  // >= rather than == so a period shortened mid-run still wraps promptly
  always_ff @(posedge clk) begin
    if (rst || !w_run) begin
      r_tcnt <= '0;
    end else if (r_tcnt >= w_period - PERIOD_W'(1)) begin
      r_tcnt <= '0;
    end else begin
      r_tcnt <= r_tcnt + PERIOD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_wdog        <= '0;
      r_mask        <= '0;
      r_got         <= '0;
      sync_o        <= 1'b0;
      frame_done    <= 1'b0;
      frame_partial <= 1'b0;
      frame_got     <= '0;
      frame_cnt     <= '0;
      missed_tick   <= 1'b0;
      dup_err       <= 1'b0;
      stray_err     <= 1'b0;
      timeout_err   <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        r_bank[i] <= '0;
      end
    end else begin
      sync_o      <= 1'b0;
      frame_done  <= 1'b0;
      missed_tick <= w_missed | (missed_tick & ~err_clr);
      dup_err     <= w_dup    | (dup_err     & ~err_clr);
      stray_err   <= w_stray  | (stray_err   & ~err_clr);
      timeout_err <= w_tout   | (timeout_err & ~err_clr);

      if (!w_run) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          // IDLE acts on the tick too, since the first tick lands in the cycle run rises
          S_IDLE, S_WAIT: begin
            if (w_tick) begin
              sync_o  <= 1'b1;
              r_got   <= '0;
              r_wdog  <= '0;
              r_mask  <= ch_mask;
              r_state <= S_COLLECT;
            end else begin
              r_state <= S_WAIT;
            end
          end
          S_COLLECT: begin
            r_wdog <= r_wdog + WD_W'(1);
            r_got  <= w_new;
            if (w_hit) begin
              r_bank[channel_i] <= data_i;
            end
            if (w_complete || w_tout) begin
              frame_done    <= 1'b1;
              frame_partial <= w_tout;
              frame_got     <= w_new;
              frame_cnt     <= frame_cnt + 16'd1;
              r_state       <= S_DONE;
            end
          end
          S_DONE: begin
            r_state <= S_WAIT;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adc_frame_scheduler.sv
// tb/tb_adc_frame_scheduler.sv - scoreboard bench for adc_frame_scheduler
module tb_adc_frame_scheduler;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst, en, op_mode, rd_en, err_clr;
  logic [15:0] period, data_i;
  logic [7:0]  ch_mask;
  logic [2:0]  channel_i, rd_addr;
  logic        sync_o, frame_done, frame_partial, busy;
  logic        missed_tick, dup_err, stray_err, timeout_err;
  logic [15:0] rd_data, frame_cnt;
  logic [7:0]  frame_got;

  adc_frame_scheduler #(.PERIOD_W(16), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .en(en), .op_mode(op_mode), .period(period),
    .ch_mask(ch_mask), .rd_en(rd_en), .data_i(data_i), .channel_i(channel_i),
    .err_clr(err_clr), .rd_addr(rd_addr), .sync_o(sync_o), .rd_data(rd_data),
    .frame_done(frame_done), .frame_partial(frame_partial), .frame_got(frame_got),
    .frame_cnt(frame_cnt), .busy(busy), .missed_tick(missed_tick),
    .dup_err(dup_err), .stray_err(stray_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int c;

  typedef struct {
    int          cyc;
    logic [7:0]  got;
    logic        partial;
    logic [15:0] cnt;
  } frame_t;

  frame_t q_frame[$];
  int     q_sync[$];
  frame_t exp_fr;
  int     exp_sync;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) step();
  endtask

  task automatic strobe(input logic [2:0] ch, input logic [15:0] d);
    rd_en = 1'b1; channel_i = ch; data_i = d;
    step();
    rd_en = 1'b0;
  endtask

  always @(negedge clk) begin
    if (sync_o === 1'b1) begin
      checks++;
      if (q_sync.size() == 0) begin
        errors++;
        $display("FAIL sync_unexpected: sync_o at cycle %0d, expected none", cyc);
      end else begin
        exp_sync = q_sync.pop_front();
        if (exp_sync != cyc) begin
          errors++;
          $display("FAIL sync_cycle: sync_o at cycle %0d, expected cycle %0d", cyc, exp_sync);
        end
      end
    end
    if (frame_done === 1'b1) begin
      checks++;
      if (q_frame.size() == 0) begin
        errors++;
        $display("FAIL frame_unexpected: frame_done at cycle %0d, expected none", cyc);
      end else begin
        exp_fr = q_frame.pop_front();
        if (exp_fr.cyc != cyc || exp_fr.got !== frame_got ||
            exp_fr.partial !== frame_partial || exp_fr.cnt !== frame_cnt) begin
          errors++;
          $display("FAIL frame: got cyc=%0d got=%0h partial=%0b cnt=%0d, expected cyc=%0d got=%0h partial=%0b cnt=%0d",
                   cyc, frame_got, frame_partial, frame_cnt,
                   exp_fr.cyc, exp_fr.got, exp_fr.partial, exp_fr.cnt);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation still running at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; en = 1'b0; op_mode = 1'b0; period = '0; ch_mask = '0;
    rd_en = 1'b0; data_i = '0; channel_i = '0; err_clr = 1'b0; rd_addr = '0;
    step(); step();
    rst = 1'b0;
    step();

    chk("reset_sync", sync_o, 0);
    chk("reset_done", {frame_done, frame_partial}, 0);
    chk("reset_got", frame_got, 0);
    chk("reset_cnt", frame_cnt, 0);
    chk("reset_busy", busy, 0);
    chk("reset_flags", {missed_tick, dup_err, stray_err, timeout_err}, 0);
    chk("reset_rd_data", rd_data, 0);

    // normal frame, then abort of the following frame via op_mode
    period = 16'd100; ch_mask = 8'h05; en = 1'b1; op_mode = 1'b1; c = cyc;
    q_sync.push_back(c + 1);
    q_sync.push_back(c + 101);
    q_frame.push_back('{c + 6, 8'h05, 1'b0, 16'd1});
    wait_until(c + 3);
    strobe(3'd0, 16'h1234);
    chk("sample_latency", rd_data, 16'h1234);
    chk("busy_collect", busy, 1);
    wait_until(c + 5);
    strobe(3'd2, 16'hABCD);
    step();
    chk("normal_got", frame_got, 8'h05);
    chk("normal_cnt", frame_cnt, 1);
    chk("normal_partial", frame_partial, 0);
    chk("busy_wait", busy, 0);
    rd_addr = 3'd2; #1;
    chk("bank2", rd_data, 16'hABCD);
    rd_addr = 3'd0;
    wait_until(c + 103);
    op_mode = 1'b0;
    step();
    chk("abort_busy", busy, 0);
    chk("abort_cnt", frame_cnt, 1);
    chk("abort_got", frame_got, 8'h05);
    chk("abort_bank0", rd_data, 16'h1234);
    step(); step();

    // timeout with only ch1 answering
    ch_mask = 8'h03; op_mode = 1'b1; c = cyc;
    q_sync.push_back(c + 1);
    q_frame.push_back('{c + 17, 8'h02, 1'b1, 16'd2});
    wait_until(c + 4);
    strobe(3'd1, 16'h5555);
    wait_until(c + 18);
    chk("timeout_err", timeout_err, 1);
    chk("timeout_partial", frame_partial, 1);
    chk("timeout_got", frame_got, 8'h02);
    wait_until(c + 20);
    op_mode = 1'b0;
    step();

    // duplicate, masked-off and stray samples
    err_clr = 1'b1; step(); err_clr = 1'b0;
    chk("clr_timeout", timeout_err, 0);
    ch_mask = 8'h06; op_mode = 1'b1; c = cyc;
    q_sync.push_back(c + 1);
    q_frame.push_back('{c + 5, 8'h06, 1'b0, 16'd3});
    wait_until(c + 1);
    strobe(3'd0, 16'hFFFF);
    strobe(3'd1, 16'h0001);
    strobe(3'd1, 16'h0002);
    strobe(3'd2, 16'h0007);
    wait_until(c + 7);
    strobe(3'd3, 16'h0009);
    chk("dup_err", dup_err, 1);
    chk("stray_err", stray_err, 1);
    chk("no_missed", missed_tick, 0);
    rd_addr = 3'd1; #1; chk("bank1_overwrite", rd_data, 16'h0002);
    rd_addr = 3'd0; #1; chk("bank0_masked", rd_data, 16'h1234);
    rd_addr = 3'd3; #1; chk("bank3_stray", rd_data, 16'h0000);
    rd_addr = 3'd2; #1; chk("bank2_new", rd_data, 16'h0007);
    rd_addr = 3'd0;
    err_clr = 1'b1; step(); err_clr = 1'b0;
    chk("err_clr_all", {missed_tick, dup_err, stray_err, timeout_err}, 0);
    op_mode = 1'b0;
    step();

    // missed tick: period 4 against a 16-cycle watchdog
    period = 16'd4; ch_mask = 8'h01;
    step();
    op_mode = 1'b1; c = cyc;
    q_sync.push_back(c + 1);
    q_sync.push_back(c + 21);
    q_frame.push_back('{c + 17, 8'h00, 1'b1, 16'd4});
    q_frame.push_back('{c + 37, 8'h00, 1'b1, 16'd5});
    wait_until(c + 3);
    chk("missed_before", missed_tick, 0);
    wait_until(c + 5);
    chk("missed_tick", missed_tick, 1);
    chk("missed_busy", busy, 1);
    wait_until(c + 40);
    op_mode = 1'b0;
    step();

    // synchronous reset mid-collect
    period = 16'd100; ch_mask = 8'hFF;
    step();
    op_mode = 1'b1; c = cyc;
    q_sync.push_back(c + 1);
    wait_until(c + 3);
    rst = 1'b1; en = 1'b0;
    step();
    rst = 1'b0;
    chk("rst_sync_done", {sync_o, frame_done, frame_partial}, 0);
    chk("rst_got", frame_got, 0);
    chk("rst_cnt", frame_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_flags", {missed_tick, dup_err, stray_err, timeout_err}, 0);
    for (int i = 0; i < 8; i++) begin
      rd_addr = 3'(i); #1;
      chk("rst_bank", rd_data, 0);
    end
    rd_addr = 3'd0;

    // period 0/1/2 with empty mask: the tick in DONE is always missed
    ch_mask = 8'h00; period = 16'd0; en = 1'b1; c = cyc;
    q_sync.push_back(c + 1);
    q_sync.push_back(c + 5);
    q_sync.push_back(c + 9);
    q_frame.push_back('{c + 2, 8'h00, 1'b0, 16'd1});
    q_frame.push_back('{c + 6, 8'h00, 1'b0, 16'd2});
    q_frame.push_back('{c + 10, 8'h00, 1'b0, 16'd3});
    wait_until(c + 3);
    chk("edge_missed", missed_tick, 1);
    wait_until(c + 4);
    period = 16'd1;
    wait_until(c + 8);
    period = 16'd2;
    wait_until(c + 12);
    en = 1'b0;
    step(); step();

    chk("sync_queue_empty", q_sync.size(), 0);
    chk("frame_queue_empty", q_frame.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
